vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  640x480@60Hz VGA timing generator; the stage directly upstream of the pixel/colour stages.
//  Divides the system clock into a pixel-rate enable and runs horizontal/vertical counters.
//  Drives pos_h, pos_v and blank into the colour generator, and hsync/vsync to the connector.
//  All outputs are registered and mutually aligned: zero skew between position, blank and syncs.
// PARAMETERS
//  CLK_DIV    2   system clocks per pixel (2 => 50 MHz board clk -> 25 MHz pixel); >=1
//  H_VISIBLE  640 visible pixels per line
//  H_FRONT    16  horizontal front porch, pixels
//  H_SYNC     96  horizontal sync width, pixels
//  H_BACK     48  horizontal back porch, pixels
//  V_VISIBLE  480 visible lines per frame
//  V_FRONT    10  vertical front porch, lines
//  V_SYNC     2   vertical sync width, lines
//  V_BACK     33  vertical back porch, lines
//  SYNC_POL   0   active level of hsync/vsync (0 = active-low)
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   run enable; low freezes all state
//  pos_h        out  10  horizontal pixel index, 0..H_TOTAL-1 (H_TOTAL=800)
//  pos_v        out  10  vertical line index, 0..V_TOTAL-1 (V_TOTAL=525)
//  blank        out  1   high when pos_h>=H_VISIBLE or pos_v>=V_VISIBLE
//  hsync        out  1   SYNC_POL while H_VISIBLE+H_FRONT <= pos_h < +H_SYNC (656..751)
//  vsync        out  1   SYNC_POL while V_VISIBLE+V_FRONT <= pos_v < +V_SYNC (490..491)
//  pix_tick     out  1   one-clk pulse in the first clk of each new pixel
//  frame_start  out  1   one-clk pulse coincident with pix_tick when pos becomes (0,0)
// BEHAVIOUR
//  Reset (async, no clk needed): div_cnt=0, pos_h=0, pos_v=0, blank=0, hsync=vsync=~SYNC_POL,
//   pix_tick=0, frame_start=0.
//  Divider: div_cnt counts 0..CLK_DIV-1 on each clk with en=1.
//   On the edge where div_cnt==CLK_DIV-1: div_cnt->0, counters advance, pix_tick<=1.
//   pix_tick<=0 on all other edges. With CLK_DIV=1, pix_tick stays high from the first en edge on.
//  Counters: on advance, pos_h+1; when pos_h==H_TOTAL-1, pos_h->0 and pos_v+1.
//   When pos_v==V_TOTAL-1 at the same time, pos_v->0.
//  blank/hsync/vsync are registered from the NEXT counter values, so they change on the same edge as pos.
//  frame_start<=1 only on an advance whose next pos is (0,0).
//   The partial frame after reset emits no frame_start.
//   First frame_start: 800*525*CLK_DIV clks after the first en edge following release.
//  en=0: div_cnt, counters and all outputs hold; pix_tick and frame_start forced 0.
//   On resume, counting continues with no skipped or repeated pixel.
//  Widths: H_TOTAL and V_TOTAL must be <=1024; an elaboration-time check fails otherwise.
//   Compares are unsigned 10-bit.
//  Reset mid-frame: immediate return to (0,0) with blank=0 and syncs inactive.
//   The first advance occurs CLK_DIV en-clocks after release.
//  Latency: pos/blank/sync visible 1 clk after the advancing edge. The downstream colour stage adds its own register.
// STRUCTURE
//  Shared header vga_timing_defs.vh: 640x480 porch/sync constants, H_TOTAL/V_TOTAL, SYNC_POL.
//   The colour stages reuse it.
//  Sub-module pix_tick_gen (CLK_DIV): divider counter and pix_tick pulse.
//   Top level holds the h/v counters and the output decode registers.
// TESTING
//  1 Reset: drive rst_n=0 mid-line at pos (300,100) between clk edges.
//    -> all outputs at reset values before the next edge.
//  2 Line timing, CLK_DIV=2:
//    -> blank rises at the pos_h 639->640 edge.
//    -> hsync low for exactly 192 clks (pos_h 656..751).
//    -> pos_h 799->0 increments pos_v; line period 1600 clks.
//  3 Frame timing:
//    -> vsync low for 3200 clks (pos_v 490..491); pos_v 524->0.
//    -> frame_start a single clk at 840000 clks after release, then every 840000 clks.
//  4 Enable: en=0 for 10 clks at pos_h=400.
//    -> pos, blank and syncs frozen; pix_tick=0.
//    -> after resume, next pos_h=401 with no gap or duplicate.
//  5 CLK_DIV=1: pix_tick constant 1; line period 800 clks; hsync low 96 clks.
//  6 Blank corners:
//    -> (639,479) blank=0; (640,479) blank=1; (0,480) blank=1; (799,524)->(0,0) blank=0.

Source files
------------

// File: rtl/vga_sync_gen_pkg.sv
// Shared timing definitions for the VGA sync generator and the colour stages
// that consume its outputs.
//  - POS_W           : width of the pos_h / pos_v counters
//  - DEF_*           : 640x480@60Hz porch/sync defaults (25 MHz pixel clock)
//  - pos_t           : counter type
//  - vga_timing_t    : registered position + decoded blank/sync bundle
//  - in_win()        : unsigned window compare used by the sync decode
package vga_sync_gen_pkg;

    localparam int POS_W         = 10;
    localparam int POS_MAX_TOTAL = 1 << POS_W;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam bit DEF_SYNC_POL  = 1'b0;

    typedef logic [POS_W-1:0] pos_t;

    typedef struct packed {
        pos_t pos_h;
        pos_t pos_v;
        logic blank;
        logic hsync;
        logic vsync;
    } vga_timing_t;

    // True while lo <= p < lo+len. Done in int so a window ending exactly at
    // 1024 does not wrap to zero.
    function automatic logic in_win(pos_t p, int lo, int len);
        return (int'(p) >= lo) && (int'(p) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bus between the sync generator and its consumers.
//  en           : run enable into the generator
//  pos_h/pos_v  : current pixel / line index
//  blank        : outside the visible area
//  hsync/vsync  : connector syncs
//  pix_tick     : first system clock of each new pixel
//  frame_start  : pulse with pix_tick when position becomes (0,0)
// master = generator, slave = colour stage / connector side.
interface vga_sync_gen_if;
    import vga_sync_gen_pkg::*;

    logic en;
    pos_t pos_h;
    pos_t pos_v;
    logic blank;
    logic hsync;
    logic vsync;
    logic pix_tick;
    logic frame_start;

    modport master (
        input  en,
        output pos_h, pos_v, blank, hsync, vsync, pix_tick, frame_start
    );

    modport slave (
        output en,
        input  pos_h, pos_v, blank, hsync, vsync, pix_tick, frame_start
    );
endinterface

// File: rtl/vga_sync_gen_pix_tick_gen.sv
// Pixel-rate divider.
//  clk, rst_n : system clock, async active-low reset
//  en         : run enable; low freezes the divider
//  adv        : combinational, high on the edge that ends a pixel (counters step)
//  pix_tick   : registered, high in the first clk of each new pixel
// With CLK_DIV=1 every enabled edge advances, so pix_tick stays high.
module pix_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic adv,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign adv  = en && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else if (en) begin
            div_cnt  <= wrap ? '0 : div_cnt + DIV_W'(1);
            pix_tick <= wrap;
        end else begin
            pix_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator (geometry parameterised).
//  clk, rst_n : system clock, async active-low reset
//  bus        : vga_sync_gen_if.master -- en in; pos_h, pos_v, blank, hsync,
//               vsync, pix_tick, frame_start out
// Position, blank and syncs are all registered on the same edge, so they are
// mutually aligned with zero skew; decode works on the next counter values.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = DEF_SYNC_POL
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master bus
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > POS_MAX_TOTAL || V_TOTAL > POS_MAX_TOTAL) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed counter range");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_sync_gen: CLK_DIV must be >= 1");
        end
    endgenerate

    logic        adv;
    logic        pix_tick;
    logic        frame_start;
    vga_timing_t cur;
    vga_timing_t nxt;

    pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.en),
        .adv      (adv),
        .pix_tick (pix_tick)
    );

    // Next position, then decode from it so the registered flags land on the
    // same edge as the position they describe.
    always_comb begin
        nxt = cur;
        if (adv) begin
            if (cur.pos_h == POS_W'(H_TOTAL - 1)) begin
                nxt.pos_h = '0;
                if (cur.pos_v == POS_W'(V_TOTAL - 1)) nxt.pos_v = '0;
                else                                  nxt.pos_v = cur.pos_v + POS_W'(1);
            end else begin
                nxt.pos_h = cur.pos_h + POS_W'(1);
            end
        end
        nxt.blank = (int'(nxt.pos_h) >= H_VISIBLE) || (int'(nxt.pos_v) >= V_VISIBLE);
        nxt.hsync = in_win(nxt.pos_h, H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        nxt.vsync = in_win(nxt.pos_v, V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur.pos_h   <= '0;
            cur.pos_v   <= '0;
            cur.blank   <= 1'b0;
            cur.hsync   <= ~SYNC_POL;
            cur.vsync   <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            if (adv) cur <= nxt;
            // Post-reset (0,0) is never "reached", so the partial frame emits no pulse.
            frame_start <= adv && (nxt.pos_h == '0) && (nxt.pos_v == '0);
        end
    end

    assign bus.pos_h       = cur.pos_h;
    assign bus.pos_v       = cur.pos_v;
    assign bus.blank       = cur.blank;
    assign bus.hsync       = cur.hsync;
    assign bus.vsync       = cur.vsync;
    assign bus.pix_tick    = pix_tick;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Two instances share one clock:
//  A: full 640x480 geometry, CLK_DIV=2 (line timing, enable pause)
//  B: 640-wide lines, 8-line frame, CLK_DIV=1 (frame timing, CLK_DIV=1,
//     mid-frame reset) so whole frames fit in a short run.
// Expected outputs come from a closed-form model indexed by enabled clk count.
module tb_vga_sync_gen;
    import vga_sync_gen_pkg::*;

    localparam int A_DIV = 2;
    localparam int B_DIV = 1;
    localparam int B_VV = 4, B_VF = 1, B_VS = 2, B_VB = 1;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       tick;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    vga_sync_gen_if bus_a ();
    vga_sync_gen_if bus_b ();

    vga_sync_gen #(.CLK_DIV(A_DIV)) u_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (bus_a.master)
    );

    vga_sync_gen #(
        .CLK_DIV(B_DIV), .V_VISIBLE(B_VV), .V_FRONT(B_VF),
        .V_SYNC(B_VS), .V_BACK(B_VB)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bus_b.master)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t qa[$];
    obs_t qb[$];
    int   na = 0, nb = 0, cyc = 0, cb = 0;
    int   run_ha = 0, run_hb = 0, run_vb = 0;
    int   prev_va = 0, last_va = 0, lines_a = 0;
    int   prev_vb = 0, last_vb = 0, last_fs = 0;

    function automatic obs_t model(int n, bit tk, int div, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb);
        obs_t m;
        int ht, vt, p, h, v;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        p  = n / div;
        h  = p % ht;
        v  = (p / ht) % vt;
        m.h     = 10'(h);
        m.v     = 10'(v);
        m.blank = (h >= hv) || (v >= vv);
        m.hs    = (h >= hv + hf && h < hv + hf + hs) ? 1'b0 : 1'b1;
        m.vs    = (v >= vv + vf && v < vv + vf + vs) ? 1'b0 : 1'b1;
        m.tick  = tk;
        m.fs    = tk && (p % (ht * vt) == 0);
        return m;
    endfunction

    function automatic obs_t model_a(int n, bit tk);
        return model(n, tk, A_DIV, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t model_b(int n, bit tk);
        return model(n, tk, B_DIV, 640, 16, 96, 48, B_VV, B_VF, B_VS, B_VB);
    endfunction

    function automatic obs_t get_a();
        return {bus_a.pos_h, bus_a.pos_v, bus_a.blank, bus_a.hsync, bus_a.vsync,
                bus_a.pix_tick, bus_a.frame_start};
    endfunction

    function automatic obs_t get_b();
        return {bus_b.pos_h, bus_b.pos_v, bus_b.blank, bus_b.hsync, bus_b.vsync,
                bus_b.pix_tick, bus_b.frame_start};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One system clock: drive enables, push expected, sample after the edge.
    task automatic step(input bit ea, input bit eb);
        bit   ta, tb;
        obs_t ea_o, eb_o;
        @(negedge clk);
        bus_a.en = ea;
        bus_b.en = eb;
        ta = 1'b0;
        tb = 1'b0;
        if (ea) begin na++; ta = (na % A_DIV == 0); end
        if (eb) begin nb++; tb = (nb % B_DIV == 0); end
        qa.push_back(model_a(na, ta));
        qb.push_back(model_b(nb, tb));
        @(posedge clk);
        #1;
        cyc++;
        cb++;
        ea_o = qa.pop_front();
        eb_o = qb.pop_front();
        chk("a_state", 32'(get_a()), 32'(ea_o));
        chk("b_state", 32'(get_b()), 32'(eb_o));

        // Sync pulse widths in clks.
        if (bus_a.hsync == 1'b0) run_ha++;
        else if (run_ha != 0) begin chk("a_hsync_width", run_ha, 192); run_ha = 0; end
        if (bus_b.hsync == 1'b0) run_hb++;
        else if (run_hb != 0) begin chk("b_hsync_width", run_hb, 96); run_hb = 0; end
        if (bus_b.vsync == 1'b0) run_vb++;
        else if (run_vb != 0) begin chk("b_vsync_width", run_vb, 1600); run_vb = 0; end

        // Line periods (A's first line carries the enable pause, so skip it).
        if (int'(bus_a.pos_v) != prev_va) begin
            if (lines_a > 0) chk("a_line_period", cyc - last_va, 1600);
            last_va = cyc;
            lines_a++;
            prev_va = int'(bus_a.pos_v);
        end
        if (int'(bus_b.pos_v) != prev_vb) begin
            chk("b_line_period", cb - last_vb, 800);
            last_vb = cb;
            prev_vb = int'(bus_b.pos_v);
        end

        if (bus_b.frame_start) begin
            chk("b_frame_period", cb - last_fs, 6400);
            last_fs = cb;
        end
    endtask

    initial begin
        bit pause_done;
        pause_done = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        #23;
        chk("a_reset", 32'(get_a()), 32'(model_a(0, 1'b0)));
        chk("b_reset", 32'(get_b()), 32'(model_b(0, 1'b0)));

        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Run B into its third frame at (300,5); pause A once at pos_h=400.
        while (nb < 17100) begin
            if (!pause_done && ((na / A_DIV) % 800 == 400)) begin
                pause_done = 1'b1;
                repeat (10) step(1'b0, 1'b1);
                step(1'b1, 1'b1);
                step(1'b1, 1'b1);
                chk("a_resume_pos_h", 32'(bus_a.pos_h), 32'd401);
            end else begin
                step(1'b1, 1'b1);
            end
        end
        chk("b_pre_reset_pos", {bus_b.pos_h, bus_b.pos_v}, {10'd300, 10'd5});

        // Asynchronous reset of B between edges.
        rst_b = 1'b0;
        #2;
        chk("b_midframe_reset", 32'(get_b()), 32'(model_b(0, 1'b0)));
        nb = 0; cb = 0; last_vb = 0; prev_vb = 0; last_fs = 0; run_hb = 0; run_vb = 0;
        rst_b = 1'b1;

        repeat (900) step(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
